// File: rtl/memory_game_core_pkg.sv
// Shared types and defaults for the card-flip memory game core.
// State encodings are fixed because the renderer decodes them in debug builds.
package memory_game_core_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PICK1 = 3'd1,
        S_PICK2 = 3'd2,
        S_SHOW  = 3'd3,
        S_WON   = 3'd4
    } state_t;

    localparam int DEF_ROWS        = 4;
    localparam int DEF_COLS        = 4;
    localparam int DEF_HOLD_CYCLES = 25_000_000;

    // Bit positions inside the packed button vector.
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_SEL   = 4;
    localparam int BTN_NUM   = 5;

endpackage

// File: rtl/memory_game_core_btn_edge_detect.sv
// Rising-edge detector for debounced button levels; one-cycle press output.
// prev resets to ones so a button held through reset never registers a press.
module btn_edge_detect #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] btn,
    output logic [WIDTH-1:0] press
);

    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk) begin
        if (!reset) prev <= '1;
        else        prev <= btn;
    end

    assign press = btn & ~prev;

endmodule

// File: rtl/memory_game_core.sv
// Memory card-flip game engine: cursor, writable deck, pick/match FSM with timed
// mismatch display, pair and move counters. All card-state outputs are registered.
module memory_game_core
    import memory_game_core_pkg::*;
#(
    parameter int ROWS        = DEF_ROWS,
    parameter int COLS        = DEF_COLS,
    parameter int VAL_W       = 3,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int MOVE_W      = 8,
    localparam int N          = ROWS * COLS,
    localparam int IDX_W      = $clog2(N),
    localparam int PAIR_W     = $clog2(N / 2 + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 up_btn,
    input  logic                 down_btn,
    input  logic                 left_btn,
    input  logic                 right_btn,
    input  logic                 select_btn,
    input  logic                 start,
    input  logic                 deck_we,
    input  logic [IDX_W-1:0]     deck_addr,
    input  logic [VAL_W-1:0]     deck_data,
    output logic [IDX_W-1:0]     cursor_pos,
    output logic [N*VAL_W-1:0]   card_values,
    output logic [N-1:0]         card_face_up,
    output logic [N-1:0]         card_matched,
    output logic [MOVE_W-1:0]    move_count,
    output logic [PAIR_W-1:0]    pairs_found,
    output logic                 game_won,
    output logic                 showing
);

    localparam int TMR_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic [BTN_NUM-1:0] press;
    state_t             state_q, state_d;
    logic [IDX_W-1:0]   row_q, row_d, col_q, col_d, cursor_d;
    logic [IDX_W-1:0]   first_q, first_d, second_q, second_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [N-1:0]       face_d, match_d;
    logic [MOVE_W-1:0]  moves_d;
    logic [PAIR_W-1:0]  pairs_d;
    logic [VAL_W-1:0]   cur_val, first_val;
    logic               deck_wr, sel, cursor_live;

    btn_edge_detect #(.WIDTH(BTN_NUM)) u_edge (
        .clk   (clk),
        .reset (reset),
        .btn   ({select_btn, right_btn, left_btn, down_btn, up_btn}),
        .press (press)
    );

    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        first_d     = first_q;
        second_d    = second_q;
        timer_d     = timer_q;
        face_d      = card_face_up;
        match_d     = card_matched;
        moves_d     = move_count;
        pairs_d     = pairs_found;
        sel         = press[BTN_SEL];
        cur_val     = card_values[int'(cursor_pos) * VAL_W +: VAL_W];
        first_val   = card_values[int'(first_q) * VAL_W +: VAL_W];
        deck_wr     = deck_we && (state_q == S_IDLE || state_q == S_WON) &&
                      (int'(deck_addr) < N);
        cursor_live = (state_q == S_PICK1) || (state_q == S_PICK2) || (state_q == S_SHOW);

        case (state_q)
            S_PICK1: begin
                if (sel && !card_face_up[cursor_pos]) begin
                    face_d[cursor_pos] = 1'b1;
                    first_d            = cursor_pos;
                    state_d            = S_PICK2;
                end
            end
            S_PICK2: begin
                if (sel && !card_face_up[cursor_pos]) begin
                    face_d[cursor_pos] = 1'b1;
                    second_d           = cursor_pos;
                    moves_d            = (move_count == '1) ? move_count : move_count + 1'b1;
                    if (cur_val == first_val) begin
                        match_d[cursor_pos] = 1'b1;
                        match_d[first_q]    = 1'b1;
                        pairs_d             = pairs_found + 1'b1;
                        state_d             = (pairs_d == PAIR_W'(N / 2)) ? S_WON : S_PICK1;
                    end else begin
                        timer_d = TMR_W'(HOLD_CYCLES - 1);
                        state_d = S_SHOW;
                    end
                end
            end
            S_SHOW: begin
                // An early-dismiss select is consumed here and never picks a card.
                if (sel || timer_q == '0) begin
                    face_d[first_q]  = 1'b0;
                    face_d[second_q] = 1'b0;
                    state_d          = S_PICK1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: ;
        endcase

        // Cursor acts after select so select always sees the pre-move position.
        if (cursor_live) begin
            if (press[BTN_UP])
                row_d = (row_q == '0) ? IDX_W'(ROWS - 1) : row_q - 1'b1;
            else if (press[BTN_DOWN])
                row_d = (row_q == IDX_W'(ROWS - 1)) ? '0 : row_q + 1'b1;
            else if (press[BTN_LEFT])
                col_d = (col_q == '0) ? IDX_W'(COLS - 1) : col_q - 1'b1;
            else if (press[BTN_RIGHT])
                col_d = (col_q == IDX_W'(COLS - 1)) ? '0 : col_q + 1'b1;
        end

        if (start) begin
            state_d = S_PICK1;
            row_d   = '0;
            col_d   = '0;
            timer_d = '0;
            face_d  = '0;
            match_d = '0;
            moves_d = '0;
            pairs_d = '0;
        end

        cursor_d = IDX_W'(int'(row_d) * COLS + int'(col_d));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            row_q        <= '0;
            col_q        <= '0;
            cursor_pos   <= '0;
            first_q      <= '0;
            second_q     <= '0;
            timer_q      <= '0;
            card_face_up <= '0;
            card_matched <= '0;
            move_count   <= '0;
            pairs_found  <= '0;
            game_won     <= 1'b0;
            showing      <= 1'b0;
            for (int i = 0; i < N; i++)
                card_values[i * VAL_W +: VAL_W] <= VAL_W'(i % (N / 2));
        end else begin
            row_q        <= row_d;
            col_q        <= col_d;
            cursor_pos   <= cursor_d;
            first_q      <= first_d;
            second_q     <= second_d;
            timer_q      <= timer_d;
            card_face_up <= face_d;
            card_matched <= match_d;
            move_count   <= moves_d;
            pairs_found  <= pairs_d;
            game_won     <= (state_d == S_WON);
            showing      <= (state_d == S_SHOW);
            if (deck_wr)
                card_values[int'(deck_addr) * VAL_W +: VAL_W] <= deck_data;
        end
    end

endmodule

// File: tb/tb_memory_game_core.sv
// Scoreboard bench for memory_game_core on a 4x4 grid with an 8-cycle mismatch hold.
module tb_memory_game_core;

    localparam logic [4:0] UP = 5'b00001, DN = 5'b00010, LT = 5'b00100,
                           RT = 5'b01000, SEL = 5'b10000;
    localparam int F_CUR = 0, F_FACE = 1, F_MATCH = 2, F_MOVES = 3,
                   F_PAIRS = 4, F_WON = 5, F_SHOW = 6, F_VALS = 7;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  btn = '0;
    logic        start = 1'b0;
    logic        deck_we = 1'b0;
    logic [3:0]  deck_addr = '0;
    logic [2:0]  deck_data = '0;
    logic [3:0]  cursor_pos;
    logic [47:0] card_values;
    logic [15:0] card_face_up, card_matched;
    logic [7:0]  move_count;
    logic [3:0]  pairs_found;
    logic        game_won, showing;

    typedef struct {
        string       tag;
        int          fld;
        logic [63:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cr = 0, cc = 0;
    logic [15:0] emask;

    always #5 clk = ~clk;

    memory_game_core #(
        .ROWS(4), .COLS(4), .VAL_W(3), .HOLD_CYCLES(8), .MOVE_W(8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .up_btn       (btn[0]),
        .down_btn     (btn[1]),
        .left_btn     (btn[2]),
        .right_btn    (btn[3]),
        .select_btn   (btn[4]),
        .start        (start),
        .deck_we      (deck_we),
        .deck_addr    (deck_addr),
        .deck_data    (deck_data),
        .cursor_pos   (cursor_pos),
        .card_values  (card_values),
        .card_face_up (card_face_up),
        .card_matched (card_matched),
        .move_count   (move_count),
        .pairs_found  (pairs_found),
        .game_won     (game_won),
        .showing      (showing)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [63:0] observe(input int fld);
        case (fld)
            F_CUR:   return 64'(cursor_pos);
            F_FACE:  return 64'(card_face_up);
            F_MATCH: return 64'(card_matched);
            F_MOVES: return 64'(move_count);
            F_PAIRS: return 64'(pairs_found);
            F_WON:   return 64'(game_won);
            F_SHOW:  return 64'(showing);
            default: return 64'(card_values);
        endcase
    endfunction

    function automatic logic [63:0] default_deck();
        logic [63:0] d = '0;
        for (int i = 0; i < 16; i++) d[i*3 +: 3] = 3'(i % 8);
        return d;
    endfunction

    task automatic expect_val(input string tag, input int fld, input logic [63:0] v);
        exp_t e;
        e.tag = tag; e.fld = fld; e.exp = v;
        sb.push_back(e);
    endtask

    task automatic expect_all(input string tag, input int cur, input logic [15:0] face,
                              input logic [15:0] mat, input int moves, input int pairs,
                              input bit won, input bit show);
        expect_val({tag, ".cursor"}, F_CUR, 64'(cur));
        expect_val({tag, ".face"},   F_FACE, 64'(face));
        expect_val({tag, ".match"},  F_MATCH, 64'(mat));
        expect_val({tag, ".moves"},  F_MOVES, 64'(moves));
        expect_val({tag, ".pairs"},  F_PAIRS, 64'(pairs));
        expect_val({tag, ".won"},    F_WON, 64'(won));
        expect_val({tag, ".show"},   F_SHOW, 64'(show));
    endtask

    // One clock; every queued expectation is compared just after the edge.
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_val(e.tag, observe(e.fld), e.exp);
        end
    endtask

    task automatic press(input logic [4:0] m);
        btn = m;
        cycle();
        btn = '0;
        cycle();
    endtask

    task automatic start_pulse();
        start = 1'b1;
        cycle();
        start = 1'b0;
        cr = 0; cc = 0; emask = '0;
    endtask

    task automatic goto_card(input int target);
        while (cr != target / 4) begin
            cr = (cr + 1) % 4;
            expect_val("nav_down", F_CUR, 64'(cr * 4 + cc));
            press(DN);
        end
        while (cc != target % 4) begin
            cc = (cc + 1) % 4;
            expect_val("nav_right", F_CUR, 64'(cr * 4 + cc));
            press(RT);
        end
    endtask

    task automatic solve_all();
        for (int k = 0; k < 8; k++) begin
            goto_card(k);
            expect_val("solve_pick1", F_FACE, 64'(emask | (16'd1 << k)));
            press(SEL);
            goto_card(k + 8);
            emask = emask | (16'd1 << k) | (16'd1 << (k + 8));
            expect_all("solve_match", k + 8, emask, emask, k + 1, k + 1, k == 7, 1'b0);
            press(SEL);
        end
    endtask

    initial begin
        logic [63:0] deck;
        emask = '0;

        // Reset and the cursor freeze in IDLE.
        btn = UP;
        cycle();
        expect_all("reset", 0, '0, '0, 0, 0, 1'b0, 1'b0);
        expect_val("reset.deck", F_VALS, default_deck());
        cycle();
        reset = 1'b1;
        btn = '0;
        cycle();
        expect_val("idle_frozen", F_CUR, 64'd0);
        press(UP);

        // Cursor wrap and direction priority.
        expect_all("start1", 0, '0, '0, 0, 0, 1'b0, 1'b0);
        start_pulse();
        expect_val("up_wrap", F_CUR, 64'd12);     press(UP);
        expect_val("left_wrap", F_CUR, 64'd15);   press(LT);
        expect_val("right_wrap", F_CUR, 64'd12);  press(RT);
        expect_val("up_over_right", F_CUR, 64'd8); press(UP | RT);

        // First match: cards 0 and 8.
        start_pulse();
        expect_val("pick0", F_FACE, 64'h1);
        press(SEL);
        goto_card(8);
        expect_all("match08", 8, 16'h0101, 16'h0101, 1, 1, 1'b0, 1'b0);
        press(SEL);

        // Full-length mismatch hold.
        start_pulse();
        press(SEL);
        goto_card(1);
        btn = SEL;
        expect_all("mis_enter", 1, 16'h3, '0, 1, 0, 1'b0, 1'b1);
        cycle();
        btn = '0;
        for (int j = 1; j < 8; j++) begin
            expect_val("hold_show", F_SHOW, 64'd1);
            expect_val("hold_face", F_FACE, 64'h3);
            cycle();
        end
        expect_val("hold_end_show", F_SHOW, 64'd0);
        expect_val("hold_end_face", F_FACE, 64'h0);
        cycle();

        // Early dismissal on the third hold cycle.
        expect_val("pick1b", F_FACE, 64'h2);
        press(SEL);
        expect_val("left_to0", F_CUR, 64'd0);
        press(LT);
        cc = 0;
        btn = SEL;
        expect_all("mis2_enter", 0, 16'h3, '0, 2, 0, 1'b0, 1'b1);
        cycle();
        btn = '0;
        expect_val("early_h1", F_SHOW, 64'd1);
        cycle();
        expect_val("early_h2", F_SHOW, 64'd1);
        cycle();
        btn = SEL;
        expect_all("early_clear", 0, '0, '0, 2, 0, 1'b0, 1'b0);
        cycle();
        btn = '0;
        expect_val("dismiss_no_pick", F_FACE, 64'h0);
        cycle();

        // Select acts on the pre-move cursor while the cursor moves.
        expect_val("selmove_face", F_FACE, 64'h1);
        expect_val("selmove_cur", F_CUR, 64'd1);
        press(SEL | RT);
        cc = 1;

        // Reselecting the first pick and selecting matched cards are ignored.
        expect_val("back_to0", F_CUR, 64'd0);
        press(LT);
        cc = 0;
        expect_all("reselect", 0, 16'h1, '0, 2, 0, 1'b0, 1'b0);
        press(SEL);
        goto_card(8);
        expect_all("match08b", 8, 16'h0101, 16'h0101, 3, 1, 1'b0, 1'b0);
        press(SEL);
        expect_all("sel_matched", 8, 16'h0101, 16'h0101, 3, 1, 1'b0, 1'b0);
        press(SEL);
        goto_card(9);
        expect_val("pick9", F_FACE, 64'h0301);
        press(SEL);
        cr = 0;
        expect_val("up_to1", F_CUR, 64'd5);  press(UP);
        expect_val("up_to1b", F_CUR, 64'd1); press(UP);
        expect_all("match19", 1, 16'h0303, 16'h0303, 4, 2, 1'b0, 1'b0);
        press(SEL);

        // Full solve; WON ignores buttons; start clears.
        start_pulse();
        solve_all();
        expect_val("won_up", F_CUR, 64'd15);
        press(UP);
        expect_all("won_sel", 15, 16'hFFFF, 16'hFFFF, 8, 8, 1'b1, 1'b0);
        press(SEL);
        expect_all("restart", 0, '0, '0, 0, 0, 1'b0, 1'b0);
        start_pulse();

        // Deck writes: rejected while playing, accepted in WON and with start.
        deck_we = 1'b1; deck_addr = 4'd3; deck_data = 3'd7;
        expect_val("we_pick1", F_VALS, default_deck());
        cycle();
        deck_we = 1'b0;
        solve_all();
        deck = default_deck();
        deck[9 +: 3] = 3'd7;
        deck_we = 1'b1; deck_addr = 4'd3; deck_data = 3'd7;
        expect_val("we_won", F_VALS, deck);
        cycle();
        deck[33 +: 3] = 3'd7;
        deck_addr = 4'd11;
        start = 1'b1;
        expect_val("we_start_deck", F_VALS, deck);
        expect_all("we_start", 0, '0, '0, 0, 0, 1'b0, 1'b0);
        cycle();
        deck_we = 1'b0;
        start = 1'b0;
        cr = 0; cc = 0;

        // Reset during SHOW.
        press(SEL);
        goto_card(1);
        btn = SEL;
        expect_val("show_before_reset", F_SHOW, 64'd1);
        cycle();
        btn = '0;
        reset = 1'b0;
        expect_all("reset_show", 0, '0, '0, 0, 0, 1'b0, 1'b0);
        expect_val("reset_show.deck", F_VALS, default_deck());
        cycle();
        reset = 1'b1;
        expect_val("idle_after_reset_cur", F_CUR, 64'd0);
        press(UP);
        expect_val("idle_after_reset_face", F_FACE, 64'd0);
        press(SEL);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
